// File: rtl/stream_job_ctrl.sv
// Job sequencer for the scaling stream processor: programs the coefficient,
// issues write then read mSGDMA descriptors, and waits for both completions.
module stream_job_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  csr_address,
  input  logic        csr_write,
  input  logic [31:0] csr_writedata,
  input  logic        csr_read,
  output logic [31:0] csr_readdata,
  output logic        coef_write,
  output logic [31:0] coef_writedata,
  output logic        wr_desc_valid,
  output logic [31:0] wr_desc_addr,
  output logic [31:0] wr_desc_len,
  input  logic        wr_desc_ready,
  output logic        rd_desc_valid,
  output logic [31:0] rd_desc_addr,
  output logic [31:0] rd_desc_len,
  input  logic        rd_desc_ready,
  input  logic        wr_done,
  input  logic        rd_done,
  output logic        irq
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE_WR, S_ISSUE_RD, S_WAIT
  } state_t;

  state_t state, state_n;

  logic             irq_en, irq_en_n;
  logic             done, done_n, error, error_n, timeout, timeout_n;
  logic [31:0]      src, src_n, dst, dst_n, len, len_n, coeff, coeff_n;
  logic             rd_seen, rd_seen_n, wr_seen, wr_seen_n;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_n;
  logic [31:0]      readdata_n;
  logic             busy, start, len_bad, irq_n;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next-state, CSR register updates and output decode
  always_comb begin
    state_n    = state;
    irq_en_n   = irq_en;
    done_n     = done;
    error_n    = error;
    timeout_n  = timeout;
    src_n      = src;
    dst_n      = dst;
    len_n      = len;
    coeff_n    = coeff;
    rd_seen_n  = rd_seen;
    wr_seen_n  = wr_seen;
    wait_cnt_n = wait_cnt;
    readdata_n = 32'd0;
    start      = 1'b0;
    busy       = (state != S_IDLE);
    len_bad    = (len == 32'd0) || (len[1:0] != 2'b00);

    if (busy) begin
      rd_seen_n = rd_seen | rd_done;
      wr_seen_n = wr_seen | wr_done;
    end

    // Job parameters are frozen while a job is in flight
    if (csr_write) begin
      case (csr_address)
        3'd0: begin
          irq_en_n = csr_writedata[1];
          start    = csr_writedata[0];
        end
        3'd1: begin
          done_n    = done    & ~csr_writedata[1];
          error_n   = error   & ~csr_writedata[2];
          timeout_n = timeout & ~csr_writedata[3];
        end
        3'd2: if (!busy) src_n   = csr_writedata;
        3'd3: if (!busy) dst_n   = csr_writedata;
        3'd4: if (!busy) len_n   = csr_writedata;
        3'd5: if (!busy) coeff_n = csr_writedata;
        default: ;
      endcase
    end

    case (state)
      S_IDLE: begin
        if (start) begin
          if (len_bad) begin
            done_n  = 1'b1;
            error_n = 1'b1;
          end else begin
            done_n    = 1'b0;
            error_n   = 1'b0;
            timeout_n = 1'b0;
            rd_seen_n = 1'b0;
            wr_seen_n = 1'b0;
            state_n   = S_LOAD;
          end
        end
      end
      S_LOAD:     state_n = S_ISSUE_WR;
      S_ISSUE_WR: if (wr_desc_ready) state_n = S_ISSUE_RD;
      S_ISSUE_RD: begin
        if (rd_desc_ready) begin
          state_n    = S_WAIT;
          wait_cnt_n = '0;
        end
      end
      S_WAIT: begin
        wait_cnt_n = wait_cnt + CNT_W'(1);
        // Completion takes priority over an expiring watchdog
        if (rd_seen_n && wr_seen_n) begin
          done_n  = 1'b1;
          state_n = S_IDLE;
        end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          done_n    = 1'b1;
          error_n   = 1'b1;
          timeout_n = 1'b1;
          state_n   = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Reads see register contents before any same-cycle write
    if (csr_read) begin
      case (csr_address)
        3'd0:    readdata_n = {30'd0, irq_en, 1'b0};
        3'd1:    readdata_n = {28'd0, timeout, error, done, busy};
        3'd2:    readdata_n = src;
        3'd3:    readdata_n = dst;
        3'd4:    readdata_n = len;
        3'd5:    readdata_n = coeff;
        default: readdata_n = 32'd0;
      endcase
    end

    irq_n = done_n & irq_en_n;
  end

  // CSR state, completion latches, watchdog and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_en        <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      timeout       <= 1'b0;
      src           <= 32'd0;
      dst           <= 32'd0;
      len           <= 32'd0;
      coeff         <= 32'd1;
      rd_seen       <= 1'b0;
      wr_seen       <= 1'b0;
      wait_cnt      <= '0;
      csr_readdata  <= 32'd0;
      coef_write    <= 1'b0;
      wr_desc_valid <= 1'b0;
      wr_desc_addr  <= 32'd0;
      wr_desc_len   <= 32'd0;
      rd_desc_valid <= 1'b0;
      rd_desc_addr  <= 32'd0;
      rd_desc_len   <= 32'd0;
      irq           <= 1'b0;
    end else begin
      irq_en        <= irq_en_n;
      done          <= done_n;
      error         <= error_n;
      timeout       <= timeout_n;
      src           <= src_n;
      dst           <= dst_n;
      len           <= len_n;
      coeff         <= coeff_n;
      rd_seen       <= rd_seen_n;
      wr_seen       <= wr_seen_n;
      wait_cnt      <= wait_cnt_n;
      csr_readdata  <= readdata_n;
      coef_write    <= (state_n == S_LOAD);
      wr_desc_valid <= (state_n == S_ISSUE_WR);
      rd_desc_valid <= (state_n == S_ISSUE_RD);
      irq           <= irq_n;
      if (state_n == S_ISSUE_WR) begin
        wr_desc_addr <= dst;
        wr_desc_len  <= len;
      end
      if (state_n == S_ISSUE_RD) begin
        rd_desc_addr <= src;
        rd_desc_len  <= len;
      end
    end
  end

  assign coef_writedata = coeff;

endmodule

// File: tb/tb_stream_job_ctrl.sv
// Directed self-checking bench for stream_job_ctrl (watchdog shortened to 16 cycles).
module tb_stream_job_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  csr_address;
  logic        csr_write;
  logic [31:0] csr_writedata;
  logic        csr_read;
  logic [31:0] csr_readdata;
  logic        coef_write;
  logic [31:0] coef_writedata;
  logic        wr_desc_valid;
  logic [31:0] wr_desc_addr;
  logic [31:0] wr_desc_len;
  logic        wr_desc_ready;
  logic        rd_desc_valid;
  logic [31:0] rd_desc_addr;
  logic [31:0] rd_desc_len;
  logic        rd_desc_ready;
  logic        wr_done;
  logic        rd_done;
  logic        irq;

  int checks = 0;
  int failures = 0;
  int coef_cnt = 0, wr_hs = 0, rd_hs = 0;
  int coef0, wr0, rd0;
  logic [31:0] rdata;

  stream_job_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .csr_address(csr_address), .csr_write(csr_write),
    .csr_writedata(csr_writedata), .csr_read(csr_read),
    .csr_readdata(csr_readdata),
    .coef_write(coef_write), .coef_writedata(coef_writedata),
    .wr_desc_valid(wr_desc_valid), .wr_desc_addr(wr_desc_addr),
    .wr_desc_len(wr_desc_len), .wr_desc_ready(wr_desc_ready),
    .rd_desc_valid(rd_desc_valid), .rd_desc_addr(rd_desc_addr),
    .rd_desc_len(rd_desc_len), .rd_desc_ready(rd_desc_ready),
    .wr_done(wr_done), .rd_done(rd_done), .irq(irq)
  );

  always #5 clk = ~clk;

  // Count coefficient writes and descriptor handshakes
  always @(posedge clk) begin
    if (coef_write) coef_cnt <= coef_cnt + 1;
    if (wr_desc_valid && wr_desc_ready) wr_hs <= wr_hs + 1;
    if (rd_desc_valid && rd_desc_ready) rd_hs <= rd_hs + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // All bus tasks start and end on a falling edge
  task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
    csr_address = a; csr_writedata = d; csr_write = 1'b1;
    @(negedge clk);
    csr_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
    csr_address = a; csr_read = 1'b1;
    @(negedge clk);
    csr_read = 1'b0;
    d = csr_readdata;
  endtask

  task automatic pulse(input logic w, input logic r);
    wr_done = w; rd_done = r;
    @(negedge clk);
    wr_done = 1'b0; rd_done = 1'b0;
  endtask

  task automatic snap();
    coef0 = coef_cnt; wr0 = wr_hs; rd0 = rd_hs;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset = 1'b1;
    csr_address = 3'd0; csr_write = 1'b0; csr_writedata = 32'd0; csr_read = 1'b0;
    wr_desc_ready = 1'b1; rd_desc_ready = 1'b1; wr_done = 1'b0; rd_done = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset values
    chk("rst_coef_we", 32'(coef_write), 32'd0);
    chk("rst_coef_data", coef_writedata, 32'd1);
    chk("rst_valids", 32'({wr_desc_valid, rd_desc_valid}), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    csr_rd(3'd1, rdata); chk("rst_status", rdata, 32'd0);
    csr_rd(3'd5, rdata); chk("rst_coeff", rdata, 32'd1);
    csr_rd(3'd6, rdata); chk("rd_addr6", rdata, 32'd0);

    // Normal job
    csr_wr(3'd2, 32'h1000);
    csr_wr(3'd3, 32'h2000);
    csr_wr(3'd4, 32'h40);
    csr_wr(3'd5, 32'd400);
    snap();
    csr_wr(3'd0, 32'h3);
    chk("n_coef_we", 32'(coef_write), 32'd1);
    chk("n_coef_data", coef_writedata, 32'd400);
    @(negedge clk);
    chk("n_wr_valid", 32'({wr_desc_valid, rd_desc_valid}), 32'd2);
    chk("n_wr_addr", wr_desc_addr, 32'h2000);
    chk("n_wr_len", wr_desc_len, 32'h40);
    @(negedge clk);
    chk("n_rd_valid", 32'({wr_desc_valid, rd_desc_valid}), 32'd1);
    chk("n_rd_addr", rd_desc_addr, 32'h1000);
    chk("n_rd_len", rd_desc_len, 32'h40);
    repeat (6) @(negedge clk);
    pulse(1'b1, 1'b0);
    @(negedge clk);
    chk("n_irq_early", 32'(irq), 32'd0);
    pulse(1'b0, 1'b1);
    chk("n_irq", 32'(irq), 32'd1);
    csr_rd(3'd1, rdata); chk("n_status", rdata, 32'h2);
    csr_wr(3'd1, 32'h2);
    chk("n_irq_clr", 32'(irq), 32'd0);
    chk("n_coef_cnt", 32'(coef_cnt - coef0), 32'd1);
    chk("n_wr_hs", 32'(wr_hs - wr0), 32'd1);
    chk("n_rd_hs", 32'(rd_hs - rd0), 32'd1);

    // Write-descriptor backpressure, then simultaneous completions
    wr_desc_ready = 1'b0;
    snap();
    csr_wr(3'd0, 32'h3);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("bp_valids", 32'({wr_desc_valid, rd_desc_valid}), 32'd2);
      chk("bp_addr", wr_desc_addr, 32'h2000);
      chk("bp_len", wr_desc_len, 32'h40);
      if (i == 5) wr_desc_ready = 1'b1;
    end
    @(negedge clk);
    chk("bp_rd_valid", 32'({wr_desc_valid, rd_desc_valid}), 32'd1);
    chk("bp_wr_hs", 32'(wr_hs - wr0), 32'd1);
    repeat (2) @(negedge clk);
    pulse(1'b1, 1'b1);
    csr_rd(3'd1, rdata); chk("sim_status", rdata, 32'h2);

    // Bad lengths
    snap();
    csr_wr(3'd4, 32'd0);
    csr_wr(3'd0, 32'h3);
    csr_rd(3'd1, rdata); chk("bad0_status", rdata, 32'h6);
    csr_wr(3'd1, 32'hE);
    csr_wr(3'd4, 32'd6);
    csr_wr(3'd0, 32'h3);
    csr_rd(3'd1, rdata); chk("bad6_status", rdata, 32'h6);
    chk("bad_coef_cnt", 32'(coef_cnt - coef0), 32'd0);
    chk("bad_hs", 32'((wr_hs - wr0) + (rd_hs - rd0)), 32'd0);
    csr_wr(3'd4, 32'h40);

    // Early wr_done during ISSUE_RD
    rd_desc_ready = 1'b0;
    csr_wr(3'd0, 32'h3);
    repeat (2) @(negedge clk);
    chk("e_rd_valid", 32'(rd_desc_valid), 32'd1);
    pulse(1'b1, 1'b0);
    rd_desc_ready = 1'b1;
    repeat (4) @(negedge clk);
    csr_rd(3'd1, rdata); chk("e_busy", rdata, 32'h1);
    pulse(1'b0, 1'b1);
    chk("e_irq", 32'(irq), 32'd1);
    csr_rd(3'd1, rdata); chk("e_status", rdata, 32'h2);

    // Completions while idle
    csr_wr(3'd1, 32'hE);
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    csr_rd(3'd1, rdata); chk("idle_status", rdata, 32'd0);
    chk("idle_irq", 32'(irq), 32'd0);

    // Timeout with only rd_done; start and SRC write while busy
    snap();
    csr_wr(3'd0, 32'h3);
    csr_wr(3'd2, 32'hDEAD);
    csr_wr(3'd0, 32'h3);
    pulse(1'b0, 1'b1);
    repeat (15) @(negedge clk);
    chk("to_irq_before", 32'(irq), 32'd0);
    @(negedge clk);
    chk("to_irq", 32'(irq), 32'd1);
    csr_rd(3'd1, rdata); chk("to_status", rdata, 32'hE);
    csr_rd(3'd2, rdata); chk("to_src_frozen", rdata, 32'h1000);
    chk("to_coef_cnt", 32'(coef_cnt - coef0), 32'd1);

    // Asynchronous reset during ISSUE_RD
    rd_desc_ready = 1'b0;
    csr_wr(3'd0, 32'h3);
    repeat (2) @(negedge clk);
    chk("ar_rd_valid_pre", 32'(rd_desc_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("ar_valids", 32'({wr_desc_valid, rd_desc_valid, coef_write}), 32'd0);
    chk("ar_rd_addr", rd_desc_addr, 32'd0);
    chk("ar_wr_addr", wr_desc_addr, 32'd0);
    chk("ar_coef_data", coef_writedata, 32'd1);
    chk("ar_irq", 32'(irq), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    rd_desc_ready = 1'b1;
    csr_rd(3'd5, rdata); chk("ar_coeff", rdata, 32'd1);
    csr_wr(3'd2, 32'h3000);
    csr_wr(3'd3, 32'h4000);
    csr_wr(3'd4, 32'h80);
    csr_wr(3'd0, 32'h1);
    chk("ar_coef_we", 32'(coef_write), 32'd1);
    @(negedge clk);
    chk("ar_wr_addr2", wr_desc_addr, 32'h4000);
    @(negedge clk);
    chk("ar_rd_addr2", rd_desc_addr, 32'h3000);
    chk("ar_rd_len2", rd_desc_len, 32'h80);
    repeat (2) @(negedge clk);
    pulse(1'b1, 1'b1);
    chk("ar_irq_off", 32'(irq), 32'd0);
    csr_rd(3'd1, rdata); chk("ar_status", rdata, 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_job_ctrl.md
# stream_job_ctrl

Job sequencer for the scaling stream processor (input × coefficient, then approximate ÷400). It sits between the CPU and three blocks: the processor's coefficient CSR, the mSGDMA read dispatcher and the mSGDMA write dispatcher. From a single CPU start command it programs the coefficient, issues the write and read descriptors, and waits for both completions. It then reports done or error through status and an interrupt.

## Interface
- TIMEOUT_CYCLES, 1048576: WAIT-state watchdog limit, in clk cycles.
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- csr_address  in  3  CPU register word index
- csr_write  in  1  CPU write strobe
- csr_writedata  in  32  CPU write data
- csr_read  in  1  CPU read strobe
- csr_readdata  out  32  read data, fixed read latency 1
- coef_write  out  1  one-cycle write strobe to the processor coefficient register
- coef_writedata  out  32  coefficient value
- wr_desc_valid  out  1  write-dispatcher descriptor valid
- wr_desc_addr  out  32  destination byte address
- wr_desc_len  out  32  byte length
- wr_desc_ready  in  1  write dispatcher accepts descriptor
- rd_desc_valid  out  1  read-dispatcher descriptor valid
- rd_desc_addr  out  32  source byte address
- rd_desc_len  out  32  byte length
- rd_desc_ready  in  1  read dispatcher accepts descriptor
- wr_done  in  1  one-cycle pulse: write DMA finished
- rd_done  in  1  one-cycle pulse: read DMA finished
- irq  out  1  level interrupt, equal to STATUS.done AND CTRL.irq_en

## Operation
- Register map:
  - 0 CTRL: bit0 start (write 1 = start, reads 0); bit1 irq_en (R/W).
  - 1 STATUS: bit0 busy (RO); bit1 done (sticky, write 1 to clear); bit2 error (sticky, write 1 to clear); bit3 timeout (sticky, write 1 to clear).
  - 2 SRC, 3 DST, 4 LEN (bytes), 5 COEFF: all R/W.
  - Addresses 6–7 read 0; writes to them are ignored.
- Reset values: COEFF = 1; all other registers 0.
- While busy, writes to SRC/DST/LEN/COEFF are ignored and the registers stay frozen. STATUS W1C and CTRL.irq_en remain writable.
- Start while busy is ignored.
- Start while idle:
  - If LEN == 0 or LEN[1:0] != 0, set error and done. No outputs are asserted and the FSM stays in IDLE.
  - Otherwise clear done, error, timeout and both completion latches, then go to LOAD.
- FSM:
  - IDLE
  - LOAD: coef_write = 1 for exactly one cycle with coef_writedata = COEFF. Next state ISSUE_WR.
  - ISSUE_WR: wr_desc_valid = 1 with DST and LEN. Hold until wr_desc_ready is sampled high, then go to ISSUE_RD. The write side is armed before any data flows.
  - ISSUE_RD: rd_desc_valid = 1 with SRC and LEN. Hold until rd_desc_ready is high, then go to WAIT.
  - WAIT: exit when both completion latches are set. Set done and go to IDLE.
- Completion latches (rd_seen, wr_seen) capture rd_done and wr_done in any busy state. Simultaneous pulses set both latches. Pulses in IDLE are ignored.
- Watchdog:
  - The counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES - 1 without both latches set: set timeout, error and done, then return to IDLE.
  - If completion and timeout fall on the same cycle, completion wins and timeout is not set.
- busy = 1 whenever the FSM is not in IDLE.
- Descriptor address, length and valid outputs are stable while valid = 1 and ready = 0.
- Reset mid-job: FSM returns to IDLE and all outputs go low immediately (asynchronous). Any in-flight DMA is the software's responsibility.

## Timing
- Output reset values: csr_readdata = 0, coef_write = 0, coef_writedata = 1, all desc_valid = 0, desc_addr/len = 0, irq = 0.
- Start written at edge T:
  - LOAD during cycle T+1 (coef_write high).
  - ISSUE_WR from T+2.
  - With ready tied high: wr_desc_valid for 1 cycle (T+2), rd_desc_valid for 1 cycle (T+3), WAIT from T+4.
- Final completion pulse at cycle C: done = 1 and busy = 0 visible from C+1. irq rises at C+1 if irq_en = 1.
- A read at edge R returns data of the registers as of R, presented on csr_readdata in cycle R+1.
- csr_read and csr_write asserted in the same cycle: the write takes effect and the read returns the pre-write value.

## Test plan
- Normal job: SRC=0x1000, DST=0x2000, LEN=0x40, COEFF=400, irq_en=1, start; dispatchers ready immediately; wr_done at +10, rd_done at +12 -> one coef_write of 400, descriptors (0x2000,0x40) then (0x1000,0x40), done=1 and irq=1 one cycle after rd_done; W1C done -> irq=0.
- Backpressure: wr_desc_ready low for 5 cycles -> wr_desc_valid held 6 cycles with stable fields, rd_desc_valid not asserted until the write handshake completes.
- Bad length: LEN=0, then LEN=6, each followed by start -> error=1 and done=1, no coef_write and no descriptors, busy never set.
- Simultaneous, early and idle completions: rd_done and wr_done in the same WAIT cycle -> done next cycle. A wr_done arriving during ISSUE_RD is latched and the job completes on the later rd_done. Pulses in IDLE -> no effect.
- Timeout (TIMEOUT_CYCLES=16): only rd_done arrives -> timeout=1 and error=1 after 16 WAIT cycles, FSM idle. Start while busy and a SRC write while busy -> ignored, SRC readback unchanged.
- Async reset during ISSUE_RD -> all outputs at reset values within the same cycle, COEFF reads back 1, a fresh job then runs normally.
